// File: rtl/md_pkg.sv
// Shared MD-unit definitions: opcode encodings and default busy-cycle counts,
// used by the sequencer, the decoder and the hazard unit.
package md_pkg;

  typedef logic [2:0] md_op_t;

  localparam md_op_t MD_MULT  = 3'd0;
  localparam md_op_t MD_MULTU = 3'd1;
  localparam md_op_t MD_DIV   = 3'd2;
  localparam md_op_t MD_DIVU  = 3'd3;
  localparam md_op_t MD_MTHI  = 3'd4;
  localparam md_op_t MD_MTLO  = 3'd5;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// E-stage to MD-unit bundle: request side plus busy and the HI/LO registers.
interface md_sequencer_if;
  import md_pkg::*;

  logic        start;
  md_op_t      op;
  logic        kill;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, kill, a, b, input busy, hi, lo);
  modport slave  (input start, op, kill, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the {hi,lo} result.
module md_arith
  import md_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [31:0] sa;
  logic signed [31:0] sb;

  // Select the product or quotient/remainder pair for the latched op
  always_comb begin
    sa       = a;
    sb       = b;
    result   = '0;
    div_zero = md_is_div(op) && (b == '0);
    case (op)
      MD_MULT:  result = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MD_MULTU: result = {32'h0, a} * {32'h0, b};
      MD_DIV: begin
        if (b == '0) begin
          result = '0;
        end else if ((a == 32'h8000_0000) && (b == '1)) begin
          // Overflow case pinned explicitly: quotient wraps, remainder is zero
          result = {32'h0, 32'h8000_0000};
        end else begin
          result = {32'(sa % sb), 32'(sa / sb)};
        end
      end
      MD_DIVU: begin
        if (b != '0) begin
          result = {a % b, a / b};
        end
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle MULT/DIV sequencer owning the architectural HI/LO registers.
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input logic           clk,
  input logic           rst_n,
  md_sequencer_if.slave md
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  md_op_t           op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [63:0]      result;
  logic             div_zero;
  logic             accept;

  assign accept = md.start && !md.kill && (state == ST_IDLE);

  md_arith u_arith (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .result   (result),
    .div_zero (div_zero)
  );

  // FSM, countdown and HI/LO update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q <= md.op;
            a_q  <= md.a;
            b_q  <= md.b;
            case (md.op)
              MD_MULT, MD_MULTU: begin
                state <= ST_MUL;
                cnt   <= CNT_W'(MULT_CYCLES);
              end
              MD_DIV, MD_DIVU: begin
                state <= ST_DIV;
                cnt   <= CNT_W'(DIV_CYCLES);
              end
              MD_MTHI: hi_q <= md.a;
              MD_MTLO: lo_q <= md.a;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt == CNT_W'(1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
            if (!div_zero) begin
              hi_q <= result[63:32];
              lo_q <= result[31:0];
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign md.busy = (state != ST_IDLE);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: stimulus pushes expected visible state,
// a negedge monitor pops entries when they come due and compares.
module tb_md_sequencer;

  localparam int unsigned NM = 5;
  localparam int unsigned ND = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  md_sequencer_if bus ();

  md_sequencer #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    bit          chk_cnt;
    int          n;
    string       name;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busy_run = 0;
  int free = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] old_hi = '0, old_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: results from plain 64-bit integer arithmetic
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        q = sa / sb;
        r = sa - q * sb;
        return {r[31:0], q[31:0]};
      end
      default: return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  // Monitor: count busy cycles and check entries that are due this cycle
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.busy) busy_run++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          chk({sb[i].name, " hilo"}, {bus.hi, bus.lo}, {sb[i].hi, sb[i].lo});
          chk({sb[i].name, " busy"}, 64'(bus.busy), 64'(sb[i].busy));
          if (sb[i].chk_cnt) begin
            chk({sb[i].name, " busy_cycles"}, 64'(busy_run), 64'(sb[i].n));
            busy_run = 0;
          end
          sb.delete(i);
        end
      end
    end
  end

  // Drive one request for one cycle; called just after a negedge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic kill, input string name);
    exp_t e;
    int k;
    int n;
    k = cyc;
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.kill = kill;
    e.name = name;
    e.due = k + 1;
    e.chk_cnt = 1'b1;
    e.n = 0;
    e.busy = 1'b0;
    if (k < free) begin
      e.chk_cnt = 1'b0;
      e.busy = (k + 1 < free);
      e.hi = e.busy ? old_hi : m_hi;
      e.lo = e.busy ? old_lo : m_lo;
    end else if (kill || op > 3'd5) begin
      e.hi = m_hi;
      e.lo = m_lo;
    end else if (op == 3'd4 || op == 3'd5) begin
      if (op == 3'd4) m_hi = a; else m_lo = a;
      e.hi = m_hi;
      e.lo = m_lo;
    end else begin
      n = (op <= 3'd1) ? NM : ND;
      old_hi = m_hi;
      old_lo = m_lo;
      if (!(op >= 3'd2 && b == 0)) {m_hi, m_lo} = ref_result(op, a, b);
      e.hi = m_hi;
      e.lo = m_lo;
      e.n = n;
      e.due = k + n + 1;
      free = e.due;
    end
    sb.push_back(e);
    @(negedge clk); #1;
    bus.start = 1'b0;
    bus.kill = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
  endtask

  task automatic wait_free();
    for (int i = 0; i < 200 && cyc < free; i++) begin
      @(negedge clk); #1;
    end
    if (cyc < free) begin
      total++;
      bad++;
      $display("FAIL wait_free timeout: actual cycle=%0d required=%0d", cyc, free);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  initial begin
    logic [2:0] rop;
    logic [31:0] ra, rb;
    exp_t e;
    bus.start = 1'b0;
    bus.op = '0;
    bus.kill = 1'b0;
    bus.a = '0;
    bus.b = '0;
    idle(3);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset hilo", {bus.hi, bus.lo}, 64'd0);
    rst_n = 1'b1;
    idle(1);

    issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult -2*3");
    wait_free();
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu max");
    wait_free();
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div -7/2");
    wait_free();
    issue(3'd3, 32'd7, 32'd0, 1'b0, "divu 7/0");
    wait_free();
    issue(3'd4, 32'h1234_5678, 32'd0, 1'b0, "mthi");
    issue(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b1, "mthi killed");
    issue(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0, "mtlo");
    issue(3'd6, 32'h1111_1111, 32'd5, 1'b0, "reserved op");
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div overflow");
    wait_free();

    issue(3'd0, 32'd1000, 32'hFFFF_FFF0, 1'b0, "mult first");
    idle(1);
    issue(3'd1, 32'd9, 32'd9, 1'b0, "mult during busy");
    wait_free();
    issue(3'd2, 32'd100, 32'hFFFF_FFFD, 1'b0, "div back-to-back");
    wait_free();

    for (int t = 0; t < 40; t++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom);
      if ($urandom_range(0, 3) != 0) wait_free();
      idle($urandom_range(0, 2));
      issue(rop, ra, rb, ($urandom_range(0, 4) == 0), "random");
    end
    wait_free();

    issue(3'd4, 32'hA5A5_0001, 32'd0, 1'b0, "pre-reset mthi");
    issue(3'd5, 32'h5A5A_0002, 32'd0, 1'b0, "pre-reset mtlo");
    issue(3'd2, 32'd100, 32'd7, 1'b0, "div reset target");
    idle(3);
    rst_n = 1'b0;
    #1;
    chk("mid-op reset busy", 64'(bus.busy), 64'd0);
    chk("mid-op reset hilo", {bus.hi, bus.lo}, 64'd0);
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    free = 0;
    busy_run = 0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    e.name = "no write after reset";
    e.due = cyc + 15;
    e.hi = '0;
    e.lo = '0;
    e.busy = 1'b0;
    e.chk_cnt = 1'b1;
    e.n = 0;
    sb.push_back(e);

    for (int i = 0; i < 300 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain timeout: actual pending=%0d required=0", sb.size());
    end
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, number of busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, number of busy cycles for DIV/DIVU.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  E-stage MD instruction valid; sampled at posedge.
REQ-007 SHALL have port op  input  3  MD opcode: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6,7 reserved.
REQ-008 SHALL have port kill  input  1  E-stage instruction flushed by exception/interrupt; cancels start in the same cycle.
REQ-009 SHALL have port a  input  32  rs operand (dividend / multiplicand / MTHI-MTLO data).
REQ-010 SHALL have port b  input  32  rt operand (divisor / multiplier).
REQ-011 SHALL have port busy  output  1  operation in flight; drives the hazard unit's MD stall.
REQ-012 SHALL have port hi  output  32  architectural HI register.
REQ-013 SHALL have port lo  output  32  architectural LO register.

Function
REQ-014 SHALL accept a request only when start=1, kill=0, and state=IDLE ("accept").
REQ-015 SHALL ignore start while busy=1; the hazard unit prevents it, and state, counter and hi/lo stay unchanged.
REQ-016 SHALL implement FSM states IDLE, MUL, DIV; on accept, MULT/MULTU -> MUL and DIV/DIVU -> DIV.
REQ-017 SHALL latch a, b and op on accept, and load a down-counter with MULT_CYCLES or DIV_CYCLES.
REQ-018 SHALL drive busy = (state != IDLE), registered, so busy rises the cycle after accept.
REQ-019 SHALL decrement the counter each cycle in MUL/DIV; at the edge where counter==1: write hi/lo, counter->0, state->IDLE.
REQ-020 SHALL therefore hold busy high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES), with the new hi/lo visible in the first cycle busy=0.
REQ-021 SHALL allow a new accept in the same cycle busy first reads 0 (back-to-back, no bubble).
REQ-022 SHALL for MULT set {hi,lo} = signed 64-bit a*b, and for MULTU the unsigned 64-bit product.
REQ-023 SHALL for DIV set lo = signed quotient truncated toward zero and hi = remainder with the dividend's sign.
REQ-024 SHALL for DIVU set lo = unsigned quotient and hi = unsigned remainder.
REQ-025 SHALL, for divide with b=0, still run DIV_CYCLES busy cycles but leave hi and lo unchanged.
REQ-026 SHALL for DIV 0x80000000 / 0xFFFFFFFF set lo=0x80000000, hi=0.
REQ-027 SHALL on accept of MTHI/MTLO write a to hi/lo at that same edge, with no busy cycle and state remaining IDLE.
REQ-028 SHALL treat reserved op values as accepted NOPs: no state change, busy=0.
REQ-029 SHALL block start when kill=1 in the same cycle, including MTHI/MTLO; kill while busy does not abort the in-flight op, which was already committed by an older instruction.
REQ-030 SHALL compute results from the latched operands only, so changes on a/b during busy have no effect.

Reset
REQ-031 SHALL on rst_n=0 immediately set state=IDLE, counter=0, busy=0, hi=0, lo=0, and the latched operands to 0.
REQ-032 SHALL on reset mid-operation discard the op with no hi/lo write, and resume normal operation from the first posedge after rst_n rises.

Structure
REQ-033 SHALL place the op encodings (MD_MULT..MD_MTLO) and the default cycle counts in shared package md_pkg, used with the decoder and the hazard unit.
REQ-034 SHALL contain one combinational sub-module md_arith (op, a, b -> 64-bit {hi,lo} result, div-by-zero flag); the FSM, counter and HI/LO registers stay in md_sequencer.

Verification
REQ-035 SHALL test MULT a=0xFFFFFFFE (-2), b=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-036 SHALL test MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 SHALL test DIV a=-7, b=2 -> busy high for 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 7/0 -> 10 busy cycles, hi/lo unchanged.
REQ-038 SHALL test MTHI a=0x12345678 with kill=0 -> hi=0x12345678 next cycle, busy stays 0; the same stimulus with kill=1 -> hi unchanged.
REQ-039 SHALL test start during busy (a second MULT at busy cycle 2) -> ignored and the first result correct; a DIV accepted in the first busy=0 cycle -> busy re-rises next cycle with no gap.
REQ-040 SHALL test rst_n pulsed low at DIV busy cycle 4 -> busy=0 and hi=lo=0 immediately, and no later write occurs.
